// File: rtl/ring_buffer_reader.sv
// rtl/ring_buffer_reader.sv - read side of the 8-bit ring buffer: shadow count, pop issue, 2-entry skid stream
// Optional sticky overflow flag port ovf when RB_READER_OVF_EN is defined.
module ring_buffer_reader #(
  parameter int DEPTH = 10,
  parameter int CW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rb_push,
  output logic          rb_pop,
  input  logic [7:0]    rb_data,
  input  logic          flush,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_data,
  output logic [CW-1:0] occupancy,
  output logic          busy
`ifdef RB_READER_OVF_EN
  ,
  output logic          ovf
`endif
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e        state_q;
  logic          busy_q;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q;
  logic          v0_q, v1_q, v0_d, v1_d;
  logic [7:0]    d0_q, d1_q, d0_d, d1_d;
  logic          xfer, drop, capture, at_max;
  logic [1:0]    used_eff;

  // Credit counts skid entries net of the byte leaving this cycle, so a
  // draining consumer keeps pops going every cycle.
  always_comb begin
    xfer     = v0_q & m_ready;
    used_eff = {1'b0, v0_q} + {1'b0, v1_q} - {1'b0, xfer};
    at_max   = (count_q == CW'(DEPTH));
    rb_pop   = !reset && !rb_push && (count_q != '0) &&
               ((state_q == ST_FLUSH) || ((used_eff + {1'b0, inflight_q}) < 2'd2));

    count_d = count_q;
    if (rb_push) begin
      if (!at_max) count_d = count_q + CW'(1);
    end else if (rb_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Skid update: shift out on transfer, then append the returning byte.
  always_comb begin
    drop    = (state_q == ST_FLUSH) || flush;
    capture = inflight_q && !drop;
    v0_d    = v0_q;
    v1_d    = v1_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    if (xfer) begin
      v0_d = v1_q;
      d0_d = d1_q;
      v1_d = 1'b0;
    end
    if (capture) begin
      if (!v0_d) begin
        v0_d = 1'b1;
        d0_d = rb_data;
      end else begin
        v1_d = 1'b1;
        d1_d = rb_data;
      end
    end
    if (drop) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_RUN;
      busy_q     <= 1'b0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      d0_q       <= 8'h00;
      d1_q       <= 8'h00;
    end else begin
      count_q    <= count_d;
      inflight_q <= rb_pop;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_FLUSH;
            busy_q  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (!flush && (count_q == '0) && !inflight_q) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RB_READER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clock) begin
    if (reset)                 ovf_q <= 1'b0;
    else if (rb_push && at_max) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`endif

  assign m_valid   = v0_q;
  assign m_data    = d0_q;
  assign occupancy = count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ring_buffer_reader.sv
// tb/tb_ring_buffer_reader.sv - self-checking bench for ring_buffer_reader (ovf checks when RB_READER_OVF_EN)
module tb_ring_buffer_reader;
  localparam int DEPTH = 10;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset, rb_push, rb_pop, flush, m_valid, m_ready, busy;
  logic [7:0]    rb_data, m_data;
  logic [CW-1:0] occupancy;
`ifdef RB_READER_OVF_EN
  logic          ovf;
`endif

  ring_buffer_reader #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clock(clock), .reset(reset), .rb_push(rb_push), .rb_pop(rb_pop),
    .rb_data(rb_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .occupancy(occupancy), .busy(busy)
`ifdef RB_READER_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    int         rdy;
  } ent_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         cnt = 0;
  int         pop_seen = 0;
  bit         st_flush = 1'b0;
  bit         last_pop = 1'b0;
  bit         m_ovf = 1'b0;
  ent_t       pipe[$];
  logic [7:0] mq[$];
  logic [7:0] rbq[$];
  logic [7:0] got[$];
  logic [7:0] wbyte;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // One clock: compare against the model, then advance the ring buffer and model.
  task automatic step();
    bit   ev, xf, ep, dut_pop, fl_old, lp_old;
    int   cnt_old;
    ent_t e;
    #2;
    ev = !st_flush && (pipe.size() > 0) && (pipe[0].rdy <= cyc);
    xf = ev && m_ready;
    ep = !reset && !rb_push && (cnt > 0) && (st_flush || ((pipe.size() - int'(xf)) < 2));
    chk("rb_pop", int'(rb_pop), int'(ep));
    chk("occupancy", int'(occupancy), cnt);
    chk("busy", int'(busy), int'(st_flush));
    chk("m_valid", int'(m_valid), int'(ev));
    if (ev) chk("m_data", int'(m_data), int'(pipe[0].d));
`ifdef RB_READER_OVF_EN
    chk("ovf", int'(ovf), int'(m_ovf));
`endif
    if (m_valid && m_ready) got.push_back(m_data);
    if (rb_pop) pop_seen++;
    dut_pop = rb_pop;
    @(posedge clock);
    #1;
    if (reset) begin
      rbq.delete();
      rb_data = 8'h00;
    end else if (rb_push) begin
      if (rbq.size() == DEPTH) void'(rbq.pop_front());
      rbq.push_back(wbyte);
    end else if (dut_pop && (rbq.size() > 0)) begin
      rb_data = rbq.pop_front();
    end
    if (reset) begin
      pipe.delete();
      mq.delete();
      cnt      = 0;
      st_flush = 1'b0;
      last_pop = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      cnt_old = cnt;
      fl_old  = st_flush;
      lp_old  = last_pop;
      if (xf) void'(pipe.pop_front());
      if (rb_push) begin
        if (cnt == DEPTH) begin
          m_ovf = 1'b1;
          void'(mq.pop_front());
        end else begin
          cnt++;
        end
        mq.push_back(wbyte);
      end else if (ep) begin
        e.d   = mq.pop_front();
        e.rdy = cyc + 2;
        pipe.push_back(e);
        cnt--;
      end
      if (!fl_old) st_flush = flush;
      else if (!flush && (cnt_old == 0) && !lp_old) st_flush = 1'b0;
      if (fl_old || flush) pipe.delete();
      last_pop = ep;
    end
    cyc++;
  endtask

  task automatic drive(bit p, logic [7:0] b, bit f, bit r, bit rs);
    rb_push = p;
    wbyte   = b;
    flush   = f;
    m_ready = r;
    reset   = rs;
    step();
  endtask

  task automatic do_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    got.delete();
    pop_seen = 0;
  endtask

  initial begin
    logic [7:0] t1 [3];
    bit         fl;
    int         pp;
    t1 = '{8'h11, 8'h22, 8'h33};
    reset = 1'b1; rb_push = 1'b0; flush = 1'b0; m_ready = 1'b0;
    rb_data = 8'h00; wbyte = 8'h00;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rb_pop", int'(rb_pop), 0);

    // In-order delivery of three pushed bytes
    for (int i = 0; i < 3; i++) drive(1'b1, t1[i], 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("t1_byte", int'(got[i]), int'(t1[i]));
    chk("t1_occupancy", int'(occupancy), 0);

    // Back-pressure: only two pops outstanding
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t2_pops", pop_seen, 2);
    chk("t2_occupancy", int'(occupancy), 3);
    chk("t2_m_valid", int'(m_valid), 1);
    chk("t2_m_data", int'(m_data), 8'hA0);
    for (int i = 0; i < 12; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t2_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) chk("t2_byte", int'(got[i]), 8'hA0 + i);

    // Pushes block pops
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1, 1'b0);
    chk("t3_no_pop_during_push", pop_seen, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t3_byte", int'(got[i]), 8'h50 + i);

    // Flush drops buffered data and drains the ring buffer
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_m_valid_before", int'(m_valid), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_m_valid_flush", int'(m_valid), 0);
    chk("t4_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t4_busy_done", int'(busy), 0);
    chk("t4_occupancy", int'(occupancy), 0);
    chk("t4_emitted", got.size(), 0);

    // Saturation at DEPTH
    do_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("t5_occupancy_10", int'(occupancy), 10);
    drive(1'b1, 8'h7A, 1'b0, 1'b0, 1'b0);
    chk("t5_occupancy_sat", int'(occupancy), 10);
`ifdef RB_READER_OVF_EN
    chk("t5_ovf_set", int'(ovf), 1);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_ovf_sticky", int'(ovf), 1);
`endif
    do_reset();
`ifdef RB_READER_OVF_EN
    chk("t5_ovf_reset", int'(ovf), 0);
`endif

    // Reset while a pop is in flight and m_valid is high
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t6_m_valid_before", int'(m_valid), 1);
    do_reset();
    m_ready = 1'b1;
    #1;
    chk("t6_m_valid", int'(m_valid), 0);
    chk("t6_occupancy", int'(occupancy), 0);
    chk("t6_rb_pop", int'(rb_pop), 0);
    for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t6_emitted", got.size(), 0);

    // Randomized traffic against the model
    fl = 1'b0;
    pp = 40;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) pp = $urandom_range(70, 15);
      if (!fl) fl = ($urandom_range(59, 0) == 0);
      else     fl = ($urandom_range(2, 0) != 0);
      drive(($urandom_range(99, 0) < pp), 8'($urandom), fl,
            ($urandom_range(9, 0) < 7), ($urandom_range(499, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
